// File: rtl/alu_share_arb.sv
// Round-robin arbiter that time-shares one ALU between the EX stage (port 0) and
// address/PC-offset generation (port 1). Optional counters: ALU_ARB_PERF_CNT_EN.
module alu_share_arb #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
`ifdef ALU_ARB_PERF_CNT_EN
    output logic [15:0]      grant0_cnt,
    output logic [15:0]      grant1_cnt,
    output logic [15:0]      contend_cnt,
`endif
    output logic             alu_flag_en
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             owner_q;
    logic             last_grant_q;
    logic             flag_en_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;

    logic             window;
    logic             both_valid;
    logic             grant1;
    logic             accept;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_flag_ok;

    always_comb begin
        window      = !rst && (state_q == StIdle || (state_q == StDone && rsp_ready));
        both_valid  = req0_valid && req1_valid;
        // Under contention the port that did not win last time gets the grant.
        grant1      = both_valid ? !last_grant_q : req1_valid;
        req0_ready  = window && req0_valid && !grant1;
        req1_ready  = window && req1_valid && grant1;
        accept      = req0_ready || req1_ready;
        sel_op      = grant1 ? req1_op : req0_op;
        sel_a       = grant1 ? req1_a : req0_a;
        sel_b       = grant1 ? req1_b : req0_b;
        sel_flag_ok = !grant1 && (sel_op[3:1] != 3'b111) && (sel_op <= 4'b0111);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            flag_en_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            case (state_q)
                StExec: begin
                    rsp_data_q  <= alu_out;
                    rsp_id_q    <= owner_q;
                    rsp_valid_q <= 1'b1;
                    flag_en_q   <= 1'b0;
                    state_q     <= StDone;
                end
                default: begin
                    if (state_q == StDone && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                    if (accept) begin
                        op_q         <= sel_op;
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        owner_q      <= grant1;
                        last_grant_q <= grant1;
                        flag_en_q    <= sel_flag_ok;
                        state_q      <= StExec;
                    end
                end
            endcase
        end
    end

`ifdef ALU_ARB_PERF_CNT_EN
    logic [15:0] grant0_cnt_q;
    logic [15:0] grant1_cnt_q;
    logic [15:0] contend_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_cnt_q  <= '0;
            grant1_cnt_q  <= '0;
            contend_cnt_q <= '0;
        end else begin
            if (req0_ready && grant0_cnt_q != 16'hFFFF) grant0_cnt_q <= grant0_cnt_q + 16'd1;
            if (req1_ready && grant1_cnt_q != 16'hFFFF) grant1_cnt_q <= grant1_cnt_q + 16'd1;
            if (window && both_valid && contend_cnt_q != 16'hFFFF) begin
                contend_cnt_q <= contend_cnt_q + 16'd1;
            end
        end
    end

    assign grant0_cnt  = grant0_cnt_q;
    assign grant1_cnt  = grant1_cnt_q;
    assign contend_cnt = contend_cnt_q;
`endif

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign alu_in1     = a_q;
    assign alu_in2     = b_q;
    assign alu_op      = op_q;
    // Reset kills flag writes in the very cycle it is asserted.
    assign alu_flag_en = flag_en_q && !rst;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: the bench plays the ALU, a cycle model predicts
// handshakes, and expected results queue at accept and are compared at response.
module tb_alu_share_arb;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         rsp_valid, rsp_id, alu_flag_en;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_data, alu_in1, alu_in2, alu_out;
    logic [3:0]   alu_op;
`ifdef ALU_ARB_PERF_CNT_EN
    logic [15:0]  grant0_cnt, grant1_cnt, contend_cnt;
`endif

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
`ifdef ALU_ARB_PERF_CNT_EN
        .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt), .contend_cnt(contend_cnt),
`endif
        .alu_flag_en(alu_flag_en)
    );

    function automatic logic [W-1:0] alu_model(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            default: return a + b + {12'h000, op};
        endcase
    endfunction

    assign alu_out = alu_model(alu_op, alu_in1, alu_in2);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle model: 0 idle, 1 exec, 2 done
    int           m_state = 0;
    logic         m_last = 1'b1;
    logic         m_flag = 1'b0;
    logic [3:0]   m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [16:0]  exp_q[$];
    int           m_g0 = 0, m_g1 = 0, m_cont = 0;

    always @(negedge clk) begin : model
        logic win, g1, e0, e1;
        logic [3:0] sop;
        logic [W-1:0] sa, sb;
        if (rst) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_flag_en", alu_flag_en, 0);
            m_state = 0; m_last = 1'b1; m_flag = 1'b0;
            m_op = '0; m_a = '0; m_b = '0;
            exp_q.delete();
            m_g0 = 0; m_g1 = 0; m_cont = 0;
        end else begin
            win = (m_state == 0) || (m_state == 2 && rsp_ready);
            g1  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e0  = win && req0_valid && !g1;
            e1  = win && req1_valid && g1;
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("flag_en", alu_flag_en, m_flag);
            chk("rsp_valid", rsp_valid, m_state == 2);
`ifdef ALU_ARB_PERF_CNT_EN
            chk("grant0_cnt", grant0_cnt, m_g0);
            chk("grant1_cnt", grant1_cnt, m_g1);
            chk("contend_cnt", contend_cnt, m_cont);
`endif
            if (m_state == 1) begin
                chk("alu_op", alu_op, m_op);
                chk("alu_in1", alu_in1, m_a);
                chk("alu_in2", alu_in2, m_b);
            end
            if (m_state == 2) begin
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("rsp_id", rsp_id, exp_q[0][16]);
                    chk("rsp_data", rsp_data, exp_q[0][15:0]);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            if (win && req0_valid && req1_valid && m_cont != 65535) m_cont++;
            if (m_state == 1) begin
                m_state = 2;
                m_flag  = 1'b0;
            end else begin
                if (m_state == 2 && rsp_ready) m_state = 0;
                if (e0 || e1) begin
                    sop = g1 ? req1_op : req0_op;
                    sa  = g1 ? req1_a : req0_a;
                    sb  = g1 ? req1_b : req0_b;
                    m_op = sop; m_a = sa; m_b = sb;
                    m_last  = g1;
                    m_flag  = !g1 && (sop[3:1] != 3'b111) && (sop <= 4'b0111);
                    m_state = 1;
                    exp_q.push_back({g1, alu_model(sop, sa, sb)});
                    if (g1) begin if (m_g1 != 65535) m_g1++; end
                    else begin if (m_g0 != 65535) m_g0++; end
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(output logic id, output longint at);
        logic seen = 1'b0;
        id = 1'b0;
        at = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin
                seen = 1'b1; id = 1'b0; at = longint'($time);
            end else if (req1_valid && req1_ready) begin
                seen = 1'b1; id = 1'b1; at = longint'($time);
            end
        end
        chk("accept_seen", seen, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic   id;
        longint t, t_prev;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_alu_op", alu_op, 0);
        chk("reset_alu_in1", alu_in1, 0);
        @(posedge clk); #1;

        // Port 0 ADD 5 + 3
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 16'h0005; req0_b = 16'h0003;
        @(negedge clk);
        chk("t1_ready0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_flag_en", alu_flag_en, 1);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_data", rsp_data, 16'h0008);
        tick(1);

        // Port 1 ADD: never touches flags
        req1_valid = 1'b1; req1_op = 4'h0; req1_a = 16'h1000; req1_b = 16'h0010;
        wait_acc(id, t);
        chk("t2_id", id, 1);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("t2_flag_en", alu_flag_en, 0);
        @(negedge clk);
        chk("t2_rsp_data", rsp_data, 16'h1010);
        chk("t2_rsp_id", rsp_id, 1);
        tick(1);

        // Continuous contention: strict alternation, one accept per 2 cycles
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 4'h1; req1_op = 4'h3;
        t_prev = 0;
        for (int k = 0; k < 8; k++) begin
            wait_acc(id, t);
            chk($sformatf("t3_grant%0d", k), id, k % 2);
            if (k > 0) chk($sformatf("t3_spacing%0d", k), 32'(t - t_prev), 20);
            t_prev = t;
            req0_a = W'($urandom); req0_b = W'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(3);

        // Result stall with a waiting port-1 request
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'h4; req0_a = 16'hFFFF; req0_b = 16'h00FF;
        wait_acc(id, t);
        chk("t4_id", id, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'h2; req1_a = 16'h0F0F; req1_b = 16'h00FF;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_rsp_data_held", rsp_data, 16'hFF00);
            chk("t4_rsp_valid_held", rsp_valid, 1);
            chk("t4_ready0_stalled", req0_ready, 0);
            chk("t4_ready1_stalled", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_ready1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        tick(3);

        // Reset during EXEC, then contention must favour port 0
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 16'h0101; req0_b = 16'h0202;
        wait_acc(id, t);
        rst = 1'b1; req0_valid = 1'b0;
        @(negedge clk);
        chk("t5_flag_in_rst", alu_flag_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_flag_en", alu_flag_en, 0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_acc(id, t);
        chk("t5_first_grant", id, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(3);

        // Random traffic with back-pressure and occasional reset
        for (int k = 0; k < 300; k++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_op = 4'($urandom); req1_op = 4'($urandom);
            req0_a = W'($urandom); req0_b = W'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        tick(5);
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
